// File: rtl/fp16_pkg.sv
// ---------------------------------------------------------------------------
// fp16_pkg
// Shared definitions for the FP16 stages of the CNN datapath: field layout
// of IEEE half precision, special-value encodings, the common sequencing
// state enum and a small input-canonicalisation helper.
// No ports (package).
// ---------------------------------------------------------------------------
package fp16_pkg;

    localparam int FP16_W   = 16;
    localparam int EXP_W    = 5;
    localparam int MANT_W   = 10;
    localparam int SIGN_POS = 15;
    localparam int EXP_LSB  = 10;
    localparam int EXP_MSB  = 14;
    localparam int EXP_BIAS = 15;

    localparam logic [EXP_W-1:0]  EXP_MAX  = 5'h1F;
    localparam logic [FP16_W-1:0] POS_ZERO = 16'h0000;
    localparam logic [FP16_W-1:0] POS_INF  = 16'h7C00;
    localparam logic [FP16_W-1:0] NEG_INF  = 16'hFC00;
    localparam logic [FP16_W-1:0] QNAN     = 16'h7E00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_ADD   = 3'd2,
        ST_NORM  = 3'd3,
        ST_OUT   = 3'd4
    } fp16_state_t;

    // Zero/subnormal inputs become signed zero; any exp=31 input becomes
    // an infinity of its sign (incoming NaN payloads are not propagated).
    function automatic logic [FP16_W-1:0] fp16_flush(input logic [FP16_W-1:0] x);
        if (x[EXP_MSB:EXP_LSB] == '0)
            return {x[SIGN_POS], 15'd0};
        else if (x[EXP_MSB:EXP_LSB] == EXP_MAX)
            return {x[SIGN_POS], EXP_MAX, 10'd0};
        else
            return x;
    endfunction

endpackage

// File: rtl/fp16_lzc.sv
// ---------------------------------------------------------------------------
// fp16_lzc
// Combinational leading-zero counter used by the accumulator's normalize
// step. An all-zero input reports W.
// Ports:
//   din  in   W    value to scan, MSB first
//   cnt  out  CW   number of zeros above the most significant one
// ---------------------------------------------------------------------------
module fp16_lzc #(
    parameter int W  = 15,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  din,
    output logic [CW-1:0] cnt
);

    // Scan upward so the highest set bit is the last one to win.
    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (din[i])
                cnt = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/fp16_accumulator.sv
// ---------------------------------------------------------------------------
// fp16_accumulator
// Serial FP16 vector summer. Accepts one element per 4 cycles, sums a vector
// terminated by in_last, then presents the FP16 sum and element count until
// the consumer takes it.
//
// Build option: FP16_RNE_EN
//   defined   -> round to nearest, ties to even, from guard/sticky bits
//   undefined -> truncate toward zero
//
// Ports:
//   clk        in   1      clock, all state on posedge
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      in_data/in_last valid
//   in_ready   out  1      element can be accepted (IDLE only)
//   in_data    in   16     FP16 element
//   in_last    in   1      element closes the vector
//   out_valid  out  1      result valid, held until out_ready
//   out_ready  in   1      consumer accepts result
//   out_data   out  16     FP16 sum
//   out_count  out  CNT_W  elements summed, saturating
//
// state  | meaning
// IDLE   | waiting for an element; in_ready high
// ALIGN  | pick larger exponent, right-shift the other significand, collect sticky
// ADD    | signed-magnitude add/subtract of the aligned significands
// NORM   | leading-one normalize, round, special cases, write accumulator
// OUT    | result presented; accumulator cleared on handoff
// ---------------------------------------------------------------------------
module fp16_accumulator
    import fp16_pkg::*;
#(
    parameter int GUARD_BITS = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [CNT_W-1:0] out_count
);

    // Significand with hidden one plus guard bits, and one more bit for the
    // carry out of an add.
    localparam int SW  = MANT_W + 1 + GUARD_BITS;
    localparam int MW  = SW + 1;
    localparam int LZW = $clog2(MW + 1);

`ifdef FP16_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    fp16_state_t      state;
    logic [15:0]      acc;
    logic [15:0]      op;
    logic             last_q;
    logic [CNT_W-1:0] count;

    logic [SW-1:0]    big_sig;
    logic [SW-1:0]    small_sig;
    logic             big_sign;
    logic             small_sign;
    logic [EXP_W-1:0] big_exp;

    logic [MW-1:0]    mag;
    logic             res_sign;
    logic [EXP_W-1:0] res_exp;

    // ------------------------------------------------------------------
    // ALIGN datapath
    // ------------------------------------------------------------------
    logic [SW-1:0]    acc_sig, op_sig;
    logic [SW-1:0]    al_big, al_small_raw, al_small, al_lost;
    logic [EXP_W-1:0] al_exp, al_shift;
    logic             al_big_sign, al_small_sign;

    always_comb begin
        acc_sig = (acc[EXP_MSB:EXP_LSB] == '0) ? '0
                : {1'b1, acc[MANT_W-1:0], {GUARD_BITS{1'b0}}};
        op_sig  = (op[EXP_MSB:EXP_LSB] == '0) ? '0
                : {1'b1, op[MANT_W-1:0], {GUARD_BITS{1'b0}}};

        // Equal exponents keep the accumulator as "big"; ADD sorts out
        // which magnitude is actually larger.
        if (op[EXP_MSB:EXP_LSB] > acc[EXP_MSB:EXP_LSB]) begin
            al_big        = op_sig;
            al_small_raw  = acc_sig;
            al_exp        = op[EXP_MSB:EXP_LSB];
            al_shift      = op[EXP_MSB:EXP_LSB] - acc[EXP_MSB:EXP_LSB];
            al_big_sign   = op[SIGN_POS];
            al_small_sign = acc[SIGN_POS];
        end else begin
            al_big        = acc_sig;
            al_small_raw  = op_sig;
            al_exp        = acc[EXP_MSB:EXP_LSB];
            al_shift      = acc[EXP_MSB:EXP_LSB] - op[EXP_MSB:EXP_LSB];
            al_big_sign   = acc[SIGN_POS];
            al_small_sign = op[SIGN_POS];
        end

        al_lost = '0;
        if (int'(al_shift) >= SW) begin
            al_small = {{(SW-1){1'b0}}, |al_small_raw};
        end else begin
            al_lost     = al_small_raw & ~({SW{1'b1}} << al_shift);
            al_small    = al_small_raw >> al_shift;
            al_small[0] = al_small[0] | (|al_lost);
        end
    end

    // ------------------------------------------------------------------
    // ADD datapath
    // ------------------------------------------------------------------
    logic [MW-1:0] add_mag;
    logic          add_sign;

    always_comb begin
        if (big_sign == small_sign) begin
            add_mag  = {1'b0, big_sig} + {1'b0, small_sig};
            add_sign = big_sign;
        end else if (big_sig >= small_sig) begin
            add_mag  = {1'b0, big_sig - small_sig};
            add_sign = big_sign;
        end else begin
            add_mag  = {1'b0, small_sig - big_sig};
            add_sign = small_sign;
        end
    end

    // ------------------------------------------------------------------
    // NORM datapath
    // ------------------------------------------------------------------
    logic [LZW-1:0]    lz;
    logic [MW-1:0]     norm;
    logic [MANT_W-1:0] mant_t;
    logic [MANT_W-1:0] mant_f;
    logic [MANT_W:0]   mant_r;
    logic              guard_b, sticky_b, round_up;
    logic              acc_inf, acc_nan, op_inf;
    int                exp_i;
    logic [15:0]       norm_res;

    fp16_lzc #(.W(MW), .CW(LZW)) u_lzc (
        .din (mag),
        .cnt (lz)
    );

    always_comb begin
        // Leading one lands on the MSB; its weight is 2^(res_exp+1-lz).
        norm     = mag << lz;
        mant_t   = norm[MW-2 -: MANT_W];
        guard_b  = norm[MW-2-MANT_W];
        sticky_b = |norm[MW-3-MANT_W:0];
        round_up = RNE & guard_b & (sticky_b | mant_t[0]);
        mant_r   = {1'b0, mant_t} + {{MANT_W{1'b0}}, round_up};
        exp_i    = int'(res_exp) + 1 - int'(lz) + int'(mant_r[MANT_W]);
        // A carry out of rounding means 1.11..1 became 10.00..0.
        mant_f   = mant_r[MANT_W] ? '0 : mant_r[MANT_W-1:0];

        acc_inf = (acc[EXP_MSB:EXP_LSB] == EXP_MAX) && (acc[MANT_W-1:0] == '0);
        acc_nan = (acc[EXP_MSB:EXP_LSB] == EXP_MAX) && (acc[MANT_W-1:0] != '0);
        op_inf  = (op[EXP_MSB:EXP_LSB] == EXP_MAX);

        if (acc_nan || (acc_inf && op_inf && (acc[SIGN_POS] != op[SIGN_POS])))
            norm_res = QNAN;
        else if (acc_inf)
            norm_res = acc;
        else if (op_inf)
            norm_res = op;
        else if (!norm[MW-1])
            norm_res = POS_ZERO;
        else if (exp_i >= int'(EXP_MAX))
            norm_res = res_sign ? NEG_INF : POS_INF;
        else if (exp_i <= 0)
            norm_res = POS_ZERO;
        else
            norm_res = {res_sign, EXP_W'(exp_i), mant_f};
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            acc        <= POS_ZERO;
            op         <= '0;
            last_q     <= 1'b0;
            count      <= '0;
            big_sig    <= '0;
            small_sig  <= '0;
            big_sign   <= 1'b0;
            small_sign <= 1'b0;
            big_exp    <= '0;
            mag        <= '0;
            res_sign   <= 1'b0;
            res_exp    <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_count  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        op       <= fp16_flush(in_data);
                        last_q   <= in_last;
                        if (count != '1)
                            count <= count + 1'b1;
                        in_ready <= 1'b0;
                        state    <= ST_ALIGN;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                ST_ALIGN: begin
                    big_sig    <= al_big;
                    small_sig  <= al_small;
                    big_sign   <= al_big_sign;
                    small_sign <= al_small_sign;
                    big_exp    <= al_exp;
                    state      <= ST_ADD;
                end
                ST_ADD: begin
                    mag      <= add_mag;
                    res_sign <= add_sign;
                    res_exp  <= big_exp;
                    state    <= ST_NORM;
                end
                ST_NORM: begin
                    acc <= norm_res;
                    if (last_q) begin
                        out_valid <= 1'b1;
                        out_data  <= norm_res;
                        out_count <= count;
                        state     <= ST_OUT;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= POS_ZERO;
                        count     <= '0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_accumulator.sv
module tb_fp16_accumulator;
    localparam int CNT_W = 8;

`ifdef FP16_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      in_data = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [15:0]      out_data;
    logic [CNT_W-1:0] out_count;

    fp16_accumulator #(.GUARD_BITS(3), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] model;
        logic [15:0] hand;
        bit          has_hand;
        int          cnt;
        int          hold;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          last_acc_cyc = 0;
    logic [15:0] vbuf[300];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        real m;
        if (h[14:10] == 5'd0) return 0.0;
        m = (1024.0 + real'(h[9:0])) / 1024.0 * pow2(int'(h[14:10]) - 15);
        return h[15] ? -m : m;
    endfunction

    function automatic logic [15:0] r2h(input real v);
        real a, m, fr;
        int  e, mi;
        bit  s;
        if (v == 0.0) return 16'h0000;
        s = (v < 0.0);
        a = s ? -v : v;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        m  = a * 1024.0;
        mi = $rtoi(m);
        fr = m - real'(mi);
        if (RNE && (fr > 0.5 || (fr == 0.5 && mi[0]))) mi++;
        if (mi == 2048) begin mi = 1024; e++; end
        if (e > 15)  return s ? 16'hFC00 : 16'h7C00;
        if (e < -14) return 16'h0000;
        return {s, 5'(e + 15), 10'(mi - 1024)};
    endfunction

    function automatic logic [15:0] model_step(input logic [15:0] acc, input logic [15:0] x_in);
        logic [15:0] x = x_in;
        bit acc_inf, acc_nan, x_inf;
        if (x[14:10] == 5'd0)  x = {x[15], 15'd0};
        if (x[14:10] == 5'h1F) x = {x[15], 5'h1F, 10'd0};
        acc_nan = (acc[14:10] == 5'h1F) && (acc[9:0] != 0);
        acc_inf = (acc[14:10] == 5'h1F) && (acc[9:0] == 0);
        x_inf   = (x[14:10] == 5'h1F);
        if (acc_nan) return 16'h7E00;
        if (acc_inf && x_inf && acc[15] != x[15]) return 16'h7E00;
        if (acc_inf) return acc;
        if (x_inf) return x;
        return r2h(h2r(acc) + h2r(x));
    endfunction

    // ---------------- driver ----------------
    task automatic send(input logic [15:0] d, input bit last);
        int g = 0;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            g++;
            if (g > 200) begin
                n_cmp++; n_bad++;
                $display("FAIL send_timeout: in_ready never rose for %h", d);
                break;
            end
        end
        if (last) last_acc_cyc = cyc;
        @(posedge clk); #1;
    endtask

    task automatic run_vec(input int n, input logic [15:0] hand, input bit has_hand, input int hold);
        exp_t e;
        logic [15:0] m = 16'h0000;
        for (int i = 0; i < n; i++) m = model_step(m, vbuf[i]);
        e.model = m; e.hand = hand; e.has_hand = has_hand;
        e.cnt = (n > 255) ? 255 : n; e.hold = hold;
        sb.push_back(e);
        for (int i = 0; i < n; i++) send(vbuf[i], i == n - 1);
        in_valid = 1'b0;
    endtask

    task automatic vec2(input logic [15:0] a, input logic [15:0] b, input logic [15:0] hand);
        vbuf[0] = a; vbuf[1] = b;
        run_vec(2, hand, 1'b1, 0);
    endtask

    task automatic drain();
        int g = 0;
        while ((sb.size() != 0 || out_valid) && g < 3000) begin @(negedge clk); g++; end
        if (g >= 3000) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d results outstanding", sb.size());
        end
        @(posedge clk); #1;
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        logic prev_v;
        int   held;
        exp_t cur;
        prev_v = 1'b0;
        held = 0;
        cur.model = 16'h0; cur.hand = 16'h0; cur.has_hand = 1'b0; cur.cnt = 0; cur.hold = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0; out_ready = 1'b0;
                continue;
            end
            if (out_valid) begin
                if (!prev_v) begin
                    chk("out_latency", 32'(cyc - last_acc_cyc), 32'd4);
                    if (sb.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_result: got %h count %0d", out_data, out_count);
                        cur.hold = 0;
                    end else begin
                        cur = sb.pop_front();
                        chk("data_model", 32'(out_data), 32'(cur.model));
                        if (cur.has_hand) chk("data_hand", 32'(out_data), 32'(cur.hand));
                        chk("count", 32'(out_count), 32'(cur.cnt));
                    end
                    held = 0;
                end else begin
                    chk("hold_data", 32'(out_data), 32'(cur.model));
                    chk("hold_count", 32'(out_count), 32'(cur.cnt));
                end
                chk("in_ready_in_out", 32'(in_ready), 32'd0);
                held++;
                out_ready = (held > cur.hold);
            end else begin
                out_ready = 1'b0;
            end
            prev_v = out_valid;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        vec2(16'h3C00, 16'h3C00, 16'h4000);
        vec2(16'h4200, 16'h4500, 16'h4800);
        vec2(16'h3C00, 16'hBC00, 16'h0000);
        vec2(16'h7BFF, 16'h7BFF, 16'h7C00);
        vec2(16'h7C00, 16'hFC00, 16'h7E00);
        vec2(16'h3C01, 16'h1000, RNE ? 16'h3C02 : 16'h3C01);
        vec2(16'h4500, 16'hC200, 16'h4000);
        vec2(16'hFC00, 16'h4000, 16'hFC00);

        vbuf[0] = 16'h7C00; vbuf[1] = 16'hFC00; vbuf[2] = 16'h3C00; vbuf[3] = 16'h7C00;
        run_vec(4, 16'h7E00, 1'b1, 0);
        vbuf[0] = 16'h8123;
        run_vec(1, 16'h0000, 1'b1, 0);
        vbuf[0] = 16'h7E01;
        run_vec(1, 16'h7C00, 1'b1, 0);

        // held output with the next vector already pending on the input
        vbuf[0] = 16'h4000; vbuf[1] = 16'h4000; vbuf[2] = 16'h3C00;
        run_vec(3, 16'h4500, 1'b1, 5);
        vbuf[0] = 16'h3C00;
        run_vec(1, 16'h3C00, 1'b1, 0);

        // count saturation: flushed subnormals sum to zero
        for (int i = 0; i < 260; i++) vbuf[i] = 16'h0001;
        run_vec(260, 16'h0000, 1'b1, 0);
        drain();

        // reset during ALIGN of the third element
        send(16'h4000, 1'b0);
        send(16'h4000, 1'b0);
        send(16'h4000, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        chk("midrst_out_count", 32'(out_count), 32'd0);
        @(posedge clk); #1;
        chk("midrst_idle_ready", 32'(in_ready), 32'd1);
        vbuf[0] = 16'h4000;
        run_vec(1, 16'h4000, 1'b1, 0);
        drain();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
